stack_ctrl: RTL and testbench
=============================

Name: stack_ctrl

Overview:
- Sequencing controller for the operand stack of the multicycle stack CPU.
- Accepts single-cycle push/pop/tos command strobes from the main controller.
- Drives a single-port synchronous stack RAM with 1-cycle read latency, and keeps the stack count, full/empty flags and top-of-stack output register.
- Reports completion with done and protocol violations with err, so the main FSM can wait on busy.

Parameters:
DATA_W, 8, stack word width
AW, 4, RAM address width
DEPTH, 16, stack capacity in words; must equal 2**AW

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
push  input  1  push request, sampled only in IDLE
pop  input  1  pop request, sampled only in IDLE
tos  input  1  read-top-without-remove request, sampled only in IDLE
din  input  DATA_W  push data, sampled on the accept edge
dout  output  DATA_W  registered top-of-stack result of the last pop/tos
busy  output  1  high while state != IDLE
done  output  1  one-cycle completion pulse, for good and errored commands
err  output  1  one-cycle error pulse, coincident with done
empty  output  1  cnt == 0
full  output  1  cnt == DEPTH
cnt  output  AW+1  current number of stacked words
ram_addr  output  AW  stack RAM address
ram_wdata  output  DATA_W  stack RAM write data
ram_we  output  1  stack RAM write enable
ram_re  output  1  stack RAM read enable
ram_rdata  input  DATA_W  stack RAM read data, valid the cycle after ram_re

Behaviour:
- States: IDLE, WR, RD, CAP. busy, ram_we, ram_re and ram_addr decode combinationally from state. ram_we/ram_re are deasserted immediately on async reset.
- Reset values: state IDLE, cnt 0, dout 0, done 0, err 0, din latch 0, ram_we 0, ram_re 0, ram_addr 0.
- Accept: in IDLE, on a rising edge with exactly one of push/pop/tos high. The command is latched and din is latched into wdata_r.
- Push, not full: IDLE -> WR.
  - WR: ram_we=1, ram_addr=cnt[AW-1:0], ram_wdata=wdata_r.
  - Edge leaving WR: cnt+1, state IDLE, done=1 for one cycle.
- Pop or tos, not empty: IDLE -> RD.
  - RD: ram_re=1, ram_addr=cnt-1.
  - RD -> CAP. CAP: ram_addr held at cnt-1, ram_re=0.
  - Edge leaving CAP: dout<=ram_rdata, state IDLE, done=1. cnt-1 for pop; cnt unchanged for tos.
- Latency from accept edge to done high: push 1 cycle; pop/tos 2 cycles.
- Error cases: push when full, pop/tos when empty, or more than one command bit high in IDLE.
  - Stay in IDLE. No RAM strobe.
  - cnt and dout unchanged.
  - done=1 and err=1 for exactly one cycle after the edge.
- Commands while busy are ignored and not queued, so no done results from them.
- A new command is accepted in the cycle done is high, since the state is IDLE then. Back-to-back push at full rate gives one push per 2 cycles.
- ram_wdata outputs wdata_r in all states. ram_addr is 0 in IDLE.
- cnt arithmetic is AW+1 bits wide and never wraps: push is blocked at DEPTH, pop is blocked at 0.
- Reset mid-operation aborts immediately:
  - WR: no RAM write and cnt=0.
  - RD/CAP: dout=0.
- empty and full are combinational from cnt. They are never both high because DEPTH>=1.

Test Plan:
- Reset: assert rst mid-cycle -> all outputs 0, empty=1, full=0, cnt=0, busy=0.
- Push 0x11, 0x22, 0x33, then tos:
  - each push gives done 1 cycle after accept and ram_we at addr 0, 1, 2;
  - tos gives dout=0x33 2 cycles after accept, with cnt=3.
- Pop three times:
  - dout = 0x33, 0x22, 0x11 in order, cnt 2, 1, 0, empty=1;
  - a fourth pop gives done=err=1 one cycle later, with no ram_re, and dout stays 0x11.
- Push 16 words 0x00..0x0F -> full=1, cnt=16. Then push 0xAA -> err pulse, ram_we never asserted, and tos returns 0x0F.
- Drive push and pop together in IDLE -> err pulse and cnt unchanged. Drive pop during WR of a push -> ignored: exactly one done, with cnt +1.
- Assert rst during the WR cycle of a push at cnt=5 -> ram_we drops the same cycle, cnt=0, state IDLE, no done.

Source files
------------

// File: rtl/stack_ctrl_if.sv
// Command/status and stack RAM signals of the operand stack controller.
// slave = controller side, master = CPU and RAM side.
interface stack_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int AW     = 4
);
  logic              push;
  logic              pop;
  logic              tos;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              busy;
  logic              done;
  logic              err;
  logic              empty;
  logic              full;
  logic [AW:0]       cnt;
  logic [AW-1:0]     ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    output push, pop, tos, din, ram_rdata,
    input  dout, busy, done, err, empty, full, cnt,
    input  ram_addr, ram_wdata, ram_we, ram_re
  );

  modport slave (
    input  push, pop, tos, din, ram_rdata,
    output dout, busy, done, err, empty, full, cnt,
    output ram_addr, ram_wdata, ram_we, ram_re
  );
endinterface

// File: rtl/stack_ctrl.sv
// Operand stack sequencer: push/pop/tos over a 1-cycle-latency stack RAM.
// RAM strobes decode from state so async reset drops them at once.
module stack_ctrl #(
  parameter int DATA_W = 8,
  parameter int AW     = 4,
  parameter int DEPTH  = 16
) (
  input  logic         clk,
  input  logic         rst,
  stack_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    CAP
  } state_t;

  localparam logic [AW:0] ONE  = (AW+1)'(1);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t            r_state;
  state_t            w_next;
  logic [AW:0]       r_cnt;
  logic [DATA_W-1:0] r_dout;
  logic [DATA_W-1:0] r_wdata;
  logic              r_done;
  logic              r_err;
  logic              r_is_pop;

  logic              w_empty;
  logic              w_full;
  logic              w_any;
  logic              w_multi;
  logic              w_done;
  logic              w_err;
  logic [AW:0]       w_cnt_m1;
  logic [AW-1:0]     w_addr;

  assign w_empty  = (r_cnt == '0);
  assign w_full   = (r_cnt == FULL);
  assign w_any    = bus.push | bus.pop | bus.tos;
  assign w_multi  = (bus.push & bus.pop)
                  | (bus.push & bus.tos)
                  | (bus.pop & bus.tos);
  assign w_cnt_m1 = r_cnt - ONE;

  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    w_err  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          if (w_multi
              || (bus.push && w_full)
              || (!bus.push && w_empty)) begin
            w_done = 1'b1;
            w_err  = 1'b1;
          end else if (bus.push) begin
            w_next = WR;
          end else begin
            w_next = RD;
          end
        end
      end
      WR: begin
        w_next = IDLE;
        w_done = 1'b1;
      end
      RD: begin
        w_next = CAP;
      end
      CAP: begin
        w_next = IDLE;
        w_done = 1'b1;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_comb begin
    w_addr = '0;
    unique case (r_state)
      WR:      w_addr = r_cnt[AW-1:0];
      RD, CAP: w_addr = w_cnt_m1[AW-1:0];
      default: w_addr = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_dout   <= '0;
      r_wdata  <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_is_pop <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_done;
      r_err   <= w_err;
      if (r_state == IDLE && w_next != IDLE) begin
        r_is_pop <= bus.pop;
        r_wdata  <= bus.din;
      end
      if (r_state == WR) begin
        r_cnt <= r_cnt + ONE;
      end
      // tos reads like pop but leaves the count alone
      if (r_state == CAP) begin
        r_dout <= bus.ram_rdata;
        if (r_is_pop) begin
          r_cnt <= w_cnt_m1;
        end
      end
    end
  end

  assign bus.dout      = r_dout;
  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;
  assign bus.cnt       = r_cnt;
  assign bus.ram_addr  = w_addr;
  assign bus.ram_wdata = r_wdata;
  assign bus.ram_we    = (r_state == WR);
  assign bus.ram_re    = (r_state == RD);

endmodule

// File: tb/tb_stack_ctrl.sv
// Self-checking bench for stack_ctrl: directed scenarios plus
// random command streams against a queue-based stack model.
module tb_stack_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  stack_ctrl_if #(.DATA_W(8), .AW(4)) bus ();

  stack_ctrl #(.DATA_W(8), .AW(4), .DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem [16];

  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_re) bus.ram_rdata <= mem[bus.ram_addr];
  end

  int total = 0;
  int bad   = 0;

  logic [7:0] stk [$];
  logic [7:0] m_dout = 8'h00;

  // Expected outcome of one command on the abstract stack.
  // lat = cycles from the accept edge until done is seen.
  task automatic model_op(input bit p, input bit po, input bit t,
                          input logic [7:0] d, output bit e,
                          output int lat, output int addr);
    int n;
    n = int'(p) + int'(po) + int'(t);
    e = 1'b0;
    lat = 0;
    addr = -1;
    if (n != 1) begin
      e = 1'b1;
    end else if (p) begin
      if (stk.size() == 16) e = 1'b1;
      else begin
        addr = stk.size();
        stk.push_back(d);
        lat = 1;
      end
    end else begin
      if (stk.size() == 0) e = 1'b1;
      else begin
        addr = stk.size() - 1;
        m_dout = stk[stk.size()-1];
        if (po) void'(stk.pop_back());
        lat = 2;
      end
    end
  endtask

  task automatic do_cmd(input bit p, input bit po, input bit t,
                        input logic [7:0] d, output int lat,
                        output bit e, output bit saw_we,
                        output bit saw_re, output int addr);
    lat = -1;
    e = 1'b0;
    saw_we = 1'b0;
    saw_re = 1'b0;
    addr = -1;
    @(negedge clk);
    bus.push = p;
    bus.pop  = po;
    bus.tos  = t;
    bus.din  = d;
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    bus.tos  = 1'b0;
    bus.din  = 8'($urandom);
    for (int k = 0; k < 8; k++) begin
      if (bus.ram_we) begin saw_we = 1'b1; addr = int'(bus.ram_addr); end
      if (bus.ram_re) begin saw_re = 1'b1; addr = int'(bus.ram_addr); end
      if (bus.done) begin
        lat = k;
        e = bus.err;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    int lat, addr;
    bit e, we, re;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    bus.tos  = 1'b0;
    bus.din  = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_cmd(1, 0, 0, 8'h99, lat, e, we, re, addr);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    total++;
    if (bus.cnt !== 5'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin
      bad++;
      $display("FAIL reset_cnt cnt=%0d empty=%b full=%b exp 0/1/0",
               bus.cnt, bus.empty, bus.full);
    end
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0
        || bus.dout !== 8'h00) begin
      bad++;
      $display("FAIL reset_status busy=%b done=%b err=%b dout=%h exp 0/0/0/00",
               bus.busy, bus.done, bus.err, bus.dout);
    end
    total++;
    if (bus.ram_we !== 1'b0 || bus.ram_re !== 1'b0
        || bus.ram_addr !== 4'd0 || bus.ram_wdata !== 8'h00) begin
      bad++;
      $display("FAIL reset_ram we=%b re=%b addr=%0d wdata=%h exp 0/0/0/00",
               bus.ram_we, bus.ram_re, bus.ram_addr, bus.ram_wdata);
    end
    @(negedge clk);
    rst = 1'b0;
    stk.delete();
    m_dout = 8'h00;
  endtask

  task automatic test_push_tos();
    logic [7:0] vals [3];
    int lat, addr, elat, eaddr;
    bit e, we, re, ee;
    vals[0] = 8'h11;
    vals[1] = 8'h22;
    vals[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      model_op(1, 0, 0, vals[i], ee, elat, eaddr);
      do_cmd(1, 0, 0, vals[i], lat, e, we, re, addr);
      total++;
      if (lat !== elat || e !== ee || we !== 1'b1 || addr !== eaddr) begin
        bad++;
        $display("FAIL push%0d lat=%0d err=%b we=%b addr=%0d exp %0d/%b/1/%0d",
                 i, lat, e, we, addr, elat, ee, eaddr);
      end
    end
    model_op(0, 0, 1, 8'h00, ee, elat, eaddr);
    do_cmd(0, 0, 1, 8'h00, lat, e, we, re, addr);
    total++;
    if (lat !== elat || e !== ee || re !== 1'b1 || addr !== eaddr
        || bus.dout !== m_dout || bus.cnt !== 5'(stk.size())) begin
      bad++;
      $display("FAIL tos lat=%0d err=%b re=%b addr=%0d dout=%h cnt=%0d exp %0d/%b/1/%0d/%h/%0d",
               lat, e, re, addr, bus.dout, bus.cnt,
               elat, ee, eaddr, m_dout, stk.size());
    end
  endtask

  task automatic test_pop();
    int lat, addr, elat, eaddr;
    bit e, we, re, ee;
    for (int i = 0; i < 3; i++) begin
      model_op(0, 1, 0, 8'h00, ee, elat, eaddr);
      do_cmd(0, 1, 0, 8'h00, lat, e, we, re, addr);
      total++;
      if (lat !== elat || e !== ee || bus.dout !== m_dout
          || bus.cnt !== 5'(stk.size()) || addr !== eaddr) begin
        bad++;
        $display("FAIL pop%0d lat=%0d err=%b dout=%h cnt=%0d addr=%0d exp %0d/%b/%h/%0d/%0d",
                 i, lat, e, bus.dout, bus.cnt, addr,
                 elat, ee, m_dout, stk.size(), eaddr);
      end
    end
    total++;
    if (bus.empty !== 1'b1) begin
      bad++;
      $display("FAIL pop_empty empty=%b exp 1", bus.empty);
    end
    model_op(0, 1, 0, 8'h00, ee, elat, eaddr);
    do_cmd(0, 1, 0, 8'h00, lat, e, we, re, addr);
    total++;
    if (lat !== 0 || e !== 1'b1 || re !== 1'b0 || bus.dout !== 8'h11
        || bus.cnt !== 5'd0) begin
      bad++;
      $display("FAIL pop_empty_err lat=%0d err=%b re=%b dout=%h cnt=%0d exp 0/1/0/11/0",
               lat, e, re, bus.dout, bus.cnt);
    end
  endtask

  task automatic test_fill();
    int lat, addr, elat, eaddr;
    bit e, we, re, ee;
    int nbad;
    nbad = 0;
    for (int i = 0; i < 16; i++) begin
      model_op(1, 0, 0, 8'(i), ee, elat, eaddr);
      do_cmd(1, 0, 0, 8'(i), lat, e, we, re, addr);
      if (lat !== 1 || e !== 1'b0 || addr !== i) nbad++;
    end
    total++;
    if (nbad != 0 || bus.full !== 1'b1 || bus.cnt !== 5'd16
        || bus.empty !== 1'b0) begin
      bad++;
      $display("FAIL fill badpush=%0d full=%b cnt=%0d empty=%b exp 0/1/16/0",
               nbad, bus.full, bus.cnt, bus.empty);
    end
    model_op(1, 0, 0, 8'hAA, ee, elat, eaddr);
    do_cmd(1, 0, 0, 8'hAA, lat, e, we, re, addr);
    total++;
    if (lat !== 0 || e !== 1'b1 || we !== 1'b0 || bus.cnt !== 5'd16) begin
      bad++;
      $display("FAIL push_full lat=%0d err=%b we=%b cnt=%0d exp 0/1/0/16",
               lat, e, we, bus.cnt);
    end
    model_op(0, 0, 1, 8'h00, ee, elat, eaddr);
    do_cmd(0, 0, 1, 8'h00, lat, e, we, re, addr);
    total++;
    if (lat !== 2 || e !== 1'b0 || bus.dout !== 8'h0F || addr !== 15) begin
      bad++;
      $display("FAIL tos_full lat=%0d err=%b dout=%h addr=%0d exp 2/0/0f/15",
               lat, e, bus.dout, addr);
    end
  endtask

  task automatic test_multi();
    int lat, addr, elat, eaddr;
    bit e, we, re, ee;
    logic [4:0] c0;
    c0 = bus.cnt;
    model_op(1, 1, 0, 8'h44, ee, elat, eaddr);
    do_cmd(1, 1, 0, 8'h44, lat, e, we, re, addr);
    total++;
    if (lat !== 0 || e !== 1'b1 || we !== 1'b0 || re !== 1'b0
        || bus.cnt !== c0) begin
      bad++;
      $display("FAIL multi lat=%0d err=%b we=%b re=%b cnt=%0d exp 0/1/0/0/%0d",
               lat, e, we, re, bus.cnt, c0);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.done !== 1'b0 || bus.err !== 1'b0) begin
      bad++;
      $display("FAIL multi_pulse done=%b err=%b exp 0/0", bus.done, bus.err);
    end
  endtask

  task automatic test_busy_ignore();
    int lat, addr, elat, eaddr, ndone;
    bit e, we, re, ee;
    model_op(0, 1, 0, 8'h00, ee, elat, eaddr);
    do_cmd(0, 1, 0, 8'h00, lat, e, we, re, addr);
    model_op(1, 0, 0, 8'h5A, ee, elat, eaddr);
    ndone = 0;
    @(negedge clk);
    bus.push = 1'b1;
    bus.din  = 8'h5A;
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    bus.pop  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      bus.pop = 1'b0;
      if (bus.done) ndone++;
    end
    total++;
    if (ndone !== 1 || bus.cnt !== 5'(stk.size()) || bus.cnt !== 5'd16) begin
      bad++;
      $display("FAIL busy_ignore dones=%0d cnt=%0d exp 1/%0d",
               ndone, bus.cnt, stk.size());
    end
    model_op(0, 0, 1, 8'h00, ee, elat, eaddr);
    do_cmd(0, 0, 1, 8'h00, lat, e, we, re, addr);
    total++;
    if (bus.dout !== 8'h5A || e !== 1'b0) begin
      bad++;
      $display("FAIL busy_ignore_tos dout=%h err=%b exp 5a/0", bus.dout, e);
    end
  endtask

  task automatic test_reset_mid();
    int lat, addr, elat, eaddr, ndone;
    bit e, we, re, ee;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    stk.delete();
    m_dout = 8'h00;
    for (int i = 0; i < 5; i++) begin
      model_op(1, 0, 0, 8'(8'h60 + i), ee, elat, eaddr);
      do_cmd(1, 0, 0, 8'(8'h60 + i), lat, e, we, re, addr);
    end
    @(negedge clk);
    bus.push = 1'b1;
    bus.din  = 8'h77;
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    total++;
    if (bus.ram_we !== 1'b1 || bus.ram_addr !== 4'd5
        || bus.ram_wdata !== 8'h77) begin
      bad++;
      $display("FAIL rstmid_wr we=%b addr=%0d wdata=%h exp 1/5/77",
               bus.ram_we, bus.ram_addr, bus.ram_wdata);
    end
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (bus.ram_we !== 1'b0 || bus.cnt !== 5'd0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL rstmid we=%b cnt=%0d busy=%b exp 0/0/0",
               bus.ram_we, bus.cnt, bus.busy);
    end
    @(negedge clk);
    rst = 1'b0;
    stk.delete();
    m_dout = 8'h00;
    ndone = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) ndone++;
    end
    total++;
    if (ndone !== 0 || bus.empty !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_nodone dones=%0d empty=%b exp 0/1",
               ndone, bus.empty);
    end
  endtask

  task automatic test_random();
    int lat, addr, elat, eaddr, r;
    bit e, we, re, ee, p, po, t;
    logic [7:0] d;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      p = 0; po = 0; t = 0;
      if (i < 150) begin
        if (r < 5) p = 1;
        else if (r < 7) po = 1;
        else if (r < 9) t = 1;
        else begin p = 1; t = 1; end
      end else begin
        if (r < 3) p = 1;
        else if (r < 7) po = 1;
        else if (r < 9) t = 1;
        else begin po = 1; t = 1; end
      end
      d = 8'($urandom);
      model_op(p, po, t, d, ee, elat, eaddr);
      do_cmd(p, po, t, d, lat, e, we, re, addr);
      total++;
      if (lat !== elat || e !== ee) begin
        bad++;
        $display("FAIL rnd_done op=%0d lat=%0d err=%b exp %0d/%b",
                 i, lat, e, elat, ee);
      end
      total++;
      if (we !== (p && !ee) || re !== (!p && !ee) || addr !== eaddr) begin
        bad++;
        $display("FAIL rnd_ram op=%0d we=%b re=%b addr=%0d exp %b/%b/%0d",
                 i, we, re, addr, p && !ee, !p && !ee, eaddr);
      end
      total++;
      if (bus.dout !== m_dout || bus.cnt !== 5'(stk.size())
          || bus.full !== (stk.size() == 16)
          || bus.empty !== (stk.size() == 0)) begin
        bad++;
        $display("FAIL rnd_state op=%0d dout=%h cnt=%0d full=%b empty=%b exp %h/%0d",
                 i, bus.dout, bus.cnt, bus.full, bus.empty,
                 m_dout, stk.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_push_tos();
    test_pop();
    test_fill();
    test_multi();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
